prio_wormhole_arbiter: RTL and testbench



---
 rtl/prio_wormhole_arbiter_if.sv | 12 +
 rtl/prio_wormhole_arbiter.sv | 123 ++++++++++++
 tb/tb_prio_wormhole_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/prio_wormhole_arbiter_if.sv
// prio_wormhole_arbiter_if: per-channel flit inputs, merged flit output and protocol error flag
interface prio_wormhole_arbiter_if #(parameter int N = 6, parameter int FLIT_SIZE = 32);
  logic [FLIT_SIZE*N-1:0] in;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_avail;
  logic [FLIT_SIZE-1:0] out;
  logic out_valid;
  logic out_avail;
  logic proto_err;
  modport master (output in, in_valid, out_avail, input in_avail, out, out_valid, proto_err);
  modport slave (input in, in_valid, out_avail, output in_avail, out, out_valid, proto_err);
endinterface

// File: rtl/prio_wormhole_arbiter.sv
// prio_wormhole_arbiter: N-input priority/round-robin wormhole flit arbiter with per-input FIFOs.
// Define AGING_EN to add per-input starvation counters that override priority at AGE_LIMIT.
module prio_wormhole_arbiter #(
  parameter int N = 6,
  parameter int FLIT_SIZE = 32,
  parameter int DEPTH = 4,
  parameter int HEADER_LEN = 2,
  parameter logic [HEADER_LEN-1:0] HEAD_FLIT = 'b10,
  parameter logic [HEADER_LEN-1:0] BODY_FLIT = 'b00,
  parameter logic [HEADER_LEN-1:0] TAIL_FLIT = 'b01,
  parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 'b11,
  parameter int CMP_POS = 29,
  parameter int CMP_LEN = 4,
  parameter int AGE_LIMIT = 15
) (
  input logic clk,
  input logic rst,
  prio_wormhole_arbiter_if.slave bus
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_t;
  logic [FLIT_SIZE-1:0] mem [N][DEPTH];
  logic [FLIT_SIZE-1:0] head [N];
  logic [PW-1:0] wp [N];
  logic [PW-1:0] rp [N];
  logic [CW-1:0] cnt [N];
  logic [N-1:0] avail, wr, rd, nonempty, elig, bad, bad_q, aged;
  logic rdy_q, any_elig, xfer, perr_q, perr_nx, sel_hs;
  logic [IW-1:0] lock_idx, lock_nx, rr_ptr, win, sel;
  logic [HEADER_LEN-1:0] sel_typ;
  logic [CMP_LEN:0] best, key;
  state_t state, state_nx;
  int j;
  for (genvar i = 0; i < N; i++) begin : g_in
    logic [HEADER_LEN-1:0] typ;
    assign head[i] = mem[i][rp[i]];
    assign typ = head[i][FLIT_SIZE-1 -: HEADER_LEN];
    assign nonempty[i] = cnt[i] != '0;
    assign avail[i] = rdy_q && cnt[i] < CW'(DEPTH);
    assign wr[i] = bus.in_valid[i] && avail[i];
    assign rd[i] = xfer && sel == IW'(i);
    assign elig[i] = nonempty[i] && (typ == HEAD_FLIT || typ == SINGLE_FLIT);
    // a BODY/TAIL at the head of any FIFO other than the locked one can never be granted
    assign bad[i] = nonempty[i] && !(typ == HEAD_FLIT || typ == SINGLE_FLIT) && !(state == LOCKED && lock_idx == IW'(i));
    always_ff @(posedge clk)
      if (wr[i]) mem[i][wp[i]] <= bus.in[FLIT_SIZE*i +: FLIT_SIZE];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end else begin
        if (wr[i]) wp[i] <= wp[i] == PW'(DEPTH - 1) ? '0 : wp[i] + 1'b1;
        if (rd[i]) rp[i] <= rp[i] == PW'(DEPTH - 1) ? '0 : rp[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(wr[i]) - CW'(rd[i]);
      end
  end
`ifdef AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  for (genvar i = 0; i < N; i++) begin : g_age
    logic [AW-1:0] age;
    assign aged[i] = age == AW'(AGE_LIMIT);
    always_ff @(posedge clk or posedge rst)
      if (rst) age <= '0;
      else if (rd[i] && sel_hs) age <= '0;
      else if (state == IDLE && elig[i] && win != IW'(i) && !aged[i]) age <= age + 1'b1;
  end
`else
  assign aged = '0;
`endif
  // scan starts just after rr_ptr, so a strict '>' hands ties to the round-robin order
  always_comb begin
    win = '0;
    best = '0;
    any_elig = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      key = {aged[j], aged[j] ? CMP_LEN'(0) : head[j][CMP_POS -: CMP_LEN]};
      if (elig[j] && (!any_elig || key > best)) begin
        any_elig = 1'b1;
        best = key;
        win = IW'(j);
      end
    end
  end
  assign sel = state == IDLE ? win : lock_idx;
  assign bus.out_valid = state == IDLE ? any_elig : state == HOLD ? 1'b1 : nonempty[lock_idx];
  assign bus.out = bus.out_valid ? head[sel] : '0;
  assign bus.in_avail = avail;
  assign bus.proto_err = perr_q;
  assign xfer = bus.out_valid && bus.out_avail;
  assign sel_typ = head[sel][FLIT_SIZE-1 -: HEADER_LEN];
  assign sel_hs = sel_typ == HEAD_FLIT || sel_typ == SINGLE_FLIT;
  always_comb begin
    state_nx = state;
    lock_nx = state == IDLE && any_elig ? win : lock_idx;
    perr_nx = |(bad & ~bad_q) || (state == LOCKED && xfer && sel_hs);
    case (state)
      IDLE: state_nx = !any_elig ? IDLE : !xfer ? HOLD : sel_typ == HEAD_FLIT ? LOCKED : IDLE;
      HOLD: state_nx = !xfer ? HOLD : sel_typ == HEAD_FLIT ? LOCKED : IDLE;
      default: state_nx = xfer && sel_typ == TAIL_FLIT ? IDLE : LOCKED;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lock_idx <= '0;
      rr_ptr <= IW'(N - 1);
      rdy_q <= 1'b0;
      perr_q <= 1'b0;
      bad_q <= '0;
    end else begin
      state <= state_nx;
      lock_idx <= lock_nx;
      rdy_q <= 1'b1;
      perr_q <= perr_nx;
      bad_q <= bad;
      if (xfer && state != LOCKED) rr_ptr <= sel;
    end
endmodule

// File: tb/tb_prio_wormhole_arbiter.sv
// tb_prio_wormhole_arbiter: directed and random stimulus against a queue-based reference model
module tb_prio_wormhole_arbiter;
  localparam int N = 4;
  localparam int D = 4;
  localparam int AL = 3;
  localparam logic [1:0] HF = 2'b10, BF = 2'b00, TF = 2'b01, SF = 2'b11;
  logic clk = 1'b0;
  logic rst;
  prio_wormhole_arbiter_if #(.N(N), .FLIT_SIZE(32)) bus();
  prio_wormhole_arbiter #(.N(N), .FLIT_SIZE(32), .DEPTH(D), .AGE_LIMIT(AL)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int nassert = 0, nfail = 0, npulse = 0, first;
  logic [31:0] q [N][$];
  logic [31:0] seen [$];
  logic [31:0] want [$];
  bit ready, lk, hd, perr_nx;
  bit bad_prev [N];
  int idx, rr;
  int age [N];
  logic [N-1:0] acc, obs_avail;
  logic [31:0] obs_out;
  logic obs_valid, obs_perr;
  int gl [N], gp [N];
  logic [3:0] gpr [N];

  function automatic logic [31:0] mk(logic [1:0] t, logic [3:0] p, logic [25:0] d);
    return {t, p, d};
  endfunction
  function automatic logic [1:0] typ(logic [31:0] f);
    return f[31:30];
  endfunction
  function automatic bit elig(int i);
    return q[i].size() > 0 && (typ(q[i][0]) == HF || typ(q[i][0]) == SF);
  endfunction
  // highest priority wins; among equals the one closest after rr wins; aged inputs outrank all
  function automatic int pick();
    int best = -1, bs = -1;
    bit any_aged = 0;
`ifdef AGING_EN
    for (int i = 0; i < N; i++) if (elig(i) && age[i] == AL) any_aged = 1;
`endif
    for (int i = 0; i < N; i++)
      if (elig(i) && (!any_aged || age[i] == AL)) begin
        int s = (any_aged ? 0 : int'(q[i][0][29:26])) * N + (N - 1 - ((i - rr - 1 + 2 * N) % N));
        if (s > bs) begin bs = s; best = i; end
      end
    return best;
  endfunction
  task automatic mreset();
    for (int i = 0; i < N; i++) begin q[i].delete(); bad_prev[i] = 0; age[i] = 0; end
    lk = 0; hd = 0; idx = 0; rr = N - 1; ready = 0; perr_nx = 0;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_seen(string tag);
    logic [31:0] s;
    chk({tag, "_len"}, 32'(seen.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      s = i < seen.size() ? seen[i] : 'x;
      chk(tag, s, want[i]);
    end
  endtask
  task automatic put(int ch, logic [31:0] f);
    bus.in[32*ch +: 32] = f;
    bus.in_valid[ch] = 1'b1;
  endtask
  task automatic cyc();
    int sel;
    bit v, x, np, bad;
    logic [31:0] eo;
    logic [N-1:0] ea;
    logic [1:0] t;
    @(negedge clk);
    sel = -1; v = 0; eo = '0; ea = '0;
    if (rst) mreset();
    else begin
      for (int i = 0; i < N; i++) ea[i] = ready && q[i].size() < D;
      sel = (lk || hd) ? idx : pick();
      v = lk ? q[idx].size() > 0 : (hd || sel >= 0);
      eo = v ? q[sel][0] : '0;
    end
    obs_valid = bus.out_valid; obs_out = bus.out; obs_avail = bus.in_avail; obs_perr = bus.proto_err;
    chk("out_valid", 32'(obs_valid), 32'(v));
    chk("out", obs_out, eo);
    chk("proto_err", 32'(obs_perr), 32'(perr_nx));
    if (rst || ready) chk("in_avail", 32'(obs_avail), 32'(ea));
    if (obs_valid) seen.push_back(obs_out);
    npulse += int'(obs_perr);
    acc = bus.in_valid & ea;
    if (!rst) begin
      x = v && bus.out_avail;
      t = typ(eo);
      np = lk && x && (t == HF || t == SF);
      for (int i = 0; i < N; i++) begin
        bad = q[i].size() > 0 && !(typ(q[i][0]) == HF || typ(q[i][0]) == SF) && !(lk && idx == i);
        if (bad && !bad_prev[i]) np = 1;
        bad_prev[i] = bad;
      end
`ifdef AGING_EN
      if (!lk && !hd) for (int i = 0; i < N; i++) if (elig(i) && i != sel && age[i] < AL) age[i]++;
`endif
      if (x) begin
        void'(q[sel].pop_front());
        if (t == HF || t == SF) age[sel] = 0;
      end
      for (int i = 0; i < N; i++) if (acc[i]) q[i].push_back(bus.in[32*i +: 32]);
      if (!lk) begin
        if (x) begin rr = sel; idx = sel; lk = t == HF; hd = 0; end
        else if (!hd && sel >= 0) begin hd = 1; idx = sel; end
      end else if (x && t == TF) lk = 0;
      perr_nx = np;
      ready = 1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.in = '0; bus.in_valid = '0; bus.out_avail = 1'b1;
    mreset();
    repeat (3) cyc();
    chk("rst_avail", 32'(obs_avail), 32'h0);
    rst = 1'b0;
    cyc();
    put(2, mk(SF, 3, 'h1)); cyc();
    chk("rel_avail", 32'(obs_avail), 32'hf);
    chk("rel_valid", 32'(obs_valid), 32'h0);
    cyc();
    chk("first_valid", 32'(obs_valid), 32'h1);
    chk("first_out", obs_out, mk(SF, 3, 'h1));
    put(0, mk(SF, 5, 'h10)); put(3, mk(SF, 9, 'h13)); cyc();
    cyc(); chk("prio_hi", obs_out, mk(SF, 9, 'h13));
    cyc(); chk("prio_lo", obs_out, mk(SF, 5, 'h10));
    put(0, mk(SF, 7, 'h20)); put(1, mk(SF, 7, 'h21)); cyc();
    cyc(); chk("tie_first", obs_out, mk(SF, 7, 'h21));
    cyc(); chk("tie_second", obs_out, mk(SF, 7, 'h20));
    seen.delete();
    put(1, mk(HF, 2, 'h30)); cyc();
    put(1, mk(BF, 0, 'h31)); put(0, mk(SF, 15, 'h40)); cyc();
    put(1, mk(BF, 0, 'h32)); cyc();
    put(1, mk(TF, 0, 'h33)); cyc();
    repeat (3) cyc();
    want = '{mk(HF, 2, 'h30), mk(BF, 0, 'h31), mk(BF, 0, 'h32), mk(TF, 0, 'h33), mk(SF, 15, 'h40)};
    chk_seen("wormhole");
    bus.out_avail = 1'b0;
    put(2, mk(HF, 2, 'h50)); cyc();
    put(2, mk(BF, 0, 'h51)); cyc();
    put(2, mk(BF, 0, 'h52)); put(0, mk(HF, 15, 'h60)); cyc();
    put(2, mk(TF, 0, 'h53)); cyc();
    chk("hold_frozen", obs_out, mk(HF, 2, 'h50));
    put(2, mk(BF, 0, 'h54)); cyc();
    chk("full_avail", 32'(obs_avail), 32'hb);
    chk("hold_frozen2", obs_out, mk(HF, 2, 'h50));
    bus.out_avail = 1'b1;
    seen.delete();
    put(0, mk(TF, 0, 'h61));
    repeat (8) cyc();
    want = '{mk(HF, 2, 'h50), mk(BF, 0, 'h51), mk(BF, 0, 'h52), mk(TF, 0, 'h53), mk(HF, 15, 'h60), mk(TF, 0, 'h61)};
    chk_seen("backpressure");
    put(3, mk(BF, 0, 'h70)); cyc();
    npulse = 0;
    repeat (4) cyc();
    chk("stray_body_pulse", 32'(npulse), 32'h1);
    seen.delete();
    put(0, mk(SF, 1, 'h71)); cyc();
    repeat (2) cyc();
    want = '{mk(SF, 1, 'h71)};
    chk_seen("blocked_input");
    npulse = 0;
    put(1, mk(HF, 4, 'h80)); cyc();
    put(1, mk(HF, 4, 'h81)); cyc();
    put(1, mk(TF, 0, 'h82)); cyc();
    repeat (3) cyc();
    chk("head_in_packet_pulse", 32'(npulse), 32'h1);
    rst = 1'b1; repeat (2) cyc();
    rst = 1'b0; cyc();
    first = -1;
    put(0, mk(HF, 1, 'h90)); put(1, mk(SF, 8, 'h91)); cyc();
    for (int k = 0; k < 8; k++) begin
      put(1, mk(SF, 8, 26'(k)));
      cyc();
      if (first < 0 && obs_valid && obs_out == mk(HF, 1, 'h90)) first = k;
    end
`ifdef AGING_EN
    chk("aging_grant", 32'(first), 32'd3);
`else
    chk("no_aging_wait", 32'(first), 32'hffffffff);
`endif
    put(0, mk(TF, 0, 'ha0));
    repeat (10) cyc();
    for (int i = 0; i < N; i++) begin gl[i] = 0; gp[i] = 0; end
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        rst = 1'b1; cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin gl[i] = 0; gp[i] = 0; end
        continue;
      end
      bus.out_avail = $urandom_range(0, 9) < 7;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) != 0) begin
          if (gp[i] == gl[i]) begin gl[i] = $urandom_range(1, 4); gp[i] = 0; gpr[i] = 4'($urandom_range(0, 15)); end
          put(i, mk(gl[i] == 1 ? SF : gp[i] == 0 ? HF : gp[i] == gl[i] - 1 ? TF : BF, gpr[i], 26'($urandom)));
        end
      cyc();
      for (int i = 0; i < N; i++) if (acc[i]) gp[i]++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
